// File: rtl/fp_pkg.sv
// Shared Q8.8 types, constants and scheduler state encoding for the divider scheduler.
package fp_pkg;

    typedef logic signed [15:0] q8_8_t;

    localparam q8_8_t Q_MAX = 16'h7FFF;
    localparam q8_8_t Q_MIN = 16'h8000;
    localparam q8_8_t Q_ONE = 16'h0100;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        GUARD,
        WAIT,
        ZBYP,
        RESP
    } sched_state_t;

    // Magnitude with the most-negative value clamped so it stays representable.
    function automatic q8_8_t q_abs(input q8_8_t x);
        if (x == Q_MIN) begin
            return Q_MAX;
        end
        return x[15] ? -x : x;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    always_comb begin
        int unsigned pos;
        logic        found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = (32'(ptr) + k) % N;
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/fp_div_sched.sv
// Round-robin scheduler sharing one iterative Q8.8 divider among NREQ requesters.
// Optional watchdog on the divider wait is enabled with FP_DIV_SCHED_WDOG_EN.
module fp_div_sched
    import fp_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned IDW      = $clog2(NREQ),
    parameter int unsigned WDOG_CYC = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0][15:0] req_a,
    input  logic [NREQ-1:0][15:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [15:0]           rsp_q,
    output logic                  rsp_dbz,
    output logic                  rsp_ovf,
    output logic                  rsp_tmo,
    output logic                  div_restart,
    output logic [15:0]           div_a,
    output logic [15:0]           div_b,
    input  logic [15:0]           div_q,
    input  logic                  div_busy,
    input  logic                  div_done,
    input  logic                  div_ovf
);

    sched_state_t state_q, state_d;

    logic [IDW-1:0]  rr_ptr_q;
    logic [IDW-1:0]  id_q;
    logic [15:0]     a_q;
    logic            neg_q;
    logic [15:0]     div_a_q, div_b_q;
    q8_8_t           rsp_q_q;
    logic            dbz_q, ovf_q;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gidx;
    logic            accept;
    logic [15:0]     acc_a, acc_b;
    logic            wait_done;
    logic            wdog_hit;
    q8_8_t           signed_q;
    logic            signed_ovf;
    q8_8_t           zbyp_q;

    rr_arbiter #(
        .N (NREQ),
        .IW(IDW)
    ) u_arb (
        .req  (req_valid),
        .ptr  (rr_ptr_q),
        .grant(grant),
        .idx  (gidx)
    );

    assign accept    = (state_q == IDLE) && (|req_valid);
    assign req_ready = (state_q == IDLE) ? grant : '0;
    assign acc_a     = req_a[gidx];
    assign acc_b     = req_b[gidx];
    assign wait_done = (state_q == WAIT) && div_done && !div_busy;

    // Negating 0x8000 yields 0x8000 again, so only the overflow flag needs care.
    always_comb begin
        signed_q   = neg_q ? q8_8_t'(-div_q) : q8_8_t'(div_q);
        signed_ovf = div_ovf | (neg_q && (div_q == Q_MIN));
    end

    always_comb begin
        if (a_q == 16'h0000) begin
            zbyp_q = '0;
        end else if (a_q[15]) begin
            zbyp_q = Q_MIN;
        end else begin
            zbyp_q = Q_MAX;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (acc_b == 16'h0000) ? ZBYP : ISSUE;
                end
            end
            ISSUE: state_d = GUARD;
            GUARD: state_d = WAIT;
            WAIT: begin
                if (wait_done || wdog_hit) begin
                    state_d = RESP;
                end
            end
            ZBYP: state_d = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            a_q      <= '0;
            neg_q    <= 1'b0;
            div_a_q  <= '0;
            div_b_q  <= '0;
            rsp_q_q  <= '0;
            dbz_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q      <= acc_a;
                neg_q    <= acc_a[15] ^ acc_b[15];
                id_q     <= gidx;
                div_a_q  <= q_abs(acc_a);
                div_b_q  <= q_abs(acc_b);
                rr_ptr_q <= (gidx == IDW'(NREQ - 1)) ? '0 : gidx + IDW'(1);
                rsp_q_q  <= '0;
                dbz_q    <= 1'b0;
                ovf_q    <= 1'b0;
            end
            if (state_q == ZBYP) begin
                rsp_q_q <= zbyp_q;
                dbz_q   <= 1'b1;
                ovf_q   <= 1'b0;
            end
            if (wait_done) begin
                rsp_q_q <= signed_q;
                dbz_q   <= 1'b0;
                ovf_q   <= signed_ovf;
            end else if (wdog_hit) begin
                rsp_q_q <= '0;
                dbz_q   <= 1'b0;
                ovf_q   <= 1'b0;
            end
        end
    end

`ifdef FP_DIV_SCHED_WDOG_EN
    localparam int unsigned CW = $clog2(WDOG_CYC + 1);

    logic [CW-1:0] wdog_q;
    logic          tmo_q;

    assign wdog_hit = (state_q == WAIT) && !wait_done && (wdog_q == CW'(WDOG_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            if (state_q == ISSUE) begin
                wdog_q <= '0;
            end else if (state_q == WAIT) begin
                wdog_q <= wdog_q + CW'(1);
            end
            if (accept) begin
                tmo_q <= 1'b0;
            end else if (wdog_hit) begin
                tmo_q <= 1'b1;
            end
        end
    end

    assign rsp_tmo = tmo_q;
`else
    logic unused_cfg;

    assign unused_cfg = ^32'(WDOG_CYC);
    assign wdog_hit   = 1'b0;
    assign rsp_tmo    = 1'b0;
`endif

    assign rsp_valid   = (state_q == RESP);
    assign rsp_id      = id_q;
    assign rsp_q       = rsp_q_q;
    assign rsp_dbz     = dbz_q;
    assign rsp_ovf     = ovf_q;
    assign div_restart = (state_q == ISSUE);
    assign div_a       = div_a_q;
    assign div_b       = div_b_q;

endmodule

// File: tb/tb_fp_div_sched.sv
// Directed bench for fp_div_sched with a behavioural 18-cycle divider and a scoreboard model.
module tb_fp_div_sched;
    import fp_pkg::*;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N-1:0][15:0] req_a;
    logic [N-1:0][15:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [15:0]       rsp_q;
    logic              rsp_dbz, rsp_ovf, rsp_tmo;
    logic              div_restart;
    logic [15:0]       div_a, div_b;
    logic [15:0]       dv_q = '0;
    logic              dv_busy = 1'b0, dv_done = 1'b0, dv_ovf = 1'b0;

    always #5 clk = ~clk;

    fp_div_sched #(
        .NREQ    (N),
        .IDW     (2),
        .WDOG_CYC(64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_q      (rsp_q),
        .rsp_dbz    (rsp_dbz),
        .rsp_ovf    (rsp_ovf),
        .rsp_tmo    (rsp_tmo),
        .div_restart(div_restart),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_q      (dv_q),
        .div_busy   (dv_busy),
        .div_done   (dv_done),
        .div_ovf    (dv_ovf)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_restart = 0;
    bit never_done = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Divider result in the bench's own terms: ((a<<8)/b), overflow above 0x7FFF.
    function automatic logic [16:0] div_ref(input logic [15:0] a, input logic [15:0] b);
        longint f;
        if (b == 16'h0000) return 17'h0;
        f = (longint'(a) << 8) / longint'(b);
        if (f > 32767) return {1'b1, 16'h8000};
        return {1'b0, 16'(f)};
    endfunction

    function automatic int mag(input logic [15:0] x);
        int v;
        v = int'($signed(x));
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return v;
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // Behavioural divider: no reset, done lingers until one cycle after the next restart.
    bit          dv_pend = 1'b0;
    int          dv_cnt = 0;
    logic [15:0] dv_la = '0, dv_lb = '0;

    always @(posedge clk) begin
        if (dv_pend) begin
            dv_busy <= 1'b1;
            dv_done <= 1'b0;
            dv_cnt  <= 17;
            dv_pend <= 1'b0;
        end else if (dv_busy && dv_cnt > 0) begin
            dv_cnt <= dv_cnt - 1;
            if (dv_cnt == 1 && !never_done) begin
                dv_busy <= 1'b0;
                dv_done <= 1'b1;
                {dv_ovf, dv_q} <= div_ref(dv_la, dv_lb);
            end
        end
        if (div_restart) begin
            dv_pend <= 1'b1;
            dv_la   <= div_a;
            dv_lb   <= div_b;
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (!rst && div_restart) n_restart++;
    end

    typedef struct {
        int          id;
        logic [15:0] q;
        logic        dbz, ovf, tmo;
        int          due;
        int          issue;
        logic [15:0] ma, mb;
    } exp_t;

    exp_t exp_q[$];
    int   m_ptr = 0;
    bit   m_busy = 1'b0;
    bit   was_rst = 1'b0;

    // Scoreboard: expected responses computed at accept from the sign/zero/latency rules.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            exp_q.delete();
            m_busy  = 1'b0;
            m_ptr   = 0;
            was_rst = 1'b1;
        end else begin
            logic [N-1:0] exp_ready;
            bit           exp_valid, exp_restart;
            int           g;
            if (was_rst) begin
                chk("reset_outputs", {rsp_valid, rsp_id, rsp_q, rsp_dbz, rsp_ovf, rsp_tmo,
                                      div_restart, req_ready, div_a, div_b}, 64'h0);
                was_rst = 1'b0;
            end
            exp_ready = '0;
            g = pick(req_valid, m_ptr);
            if (!m_busy && g >= 0) exp_ready[g] = 1'b1;
            chk("req_ready", req_ready, exp_ready);

            exp_valid   = 1'b0;
            exp_restart = 1'b0;
            if (exp_q.size() > 0) begin
                exp_valid   = (cyc >= exp_q[0].due);
                exp_restart = (cyc == exp_q[0].issue);
            end
            chk("rsp_valid", rsp_valid, exp_valid);
            chk("div_restart", div_restart, exp_restart);
            if (exp_restart) begin
                chk("div_a", div_a, exp_q[0].ma);
                chk("div_b", div_b, exp_q[0].mb);
            end
            if (exp_valid && rsp_valid) begin
                chk("rsp_id", rsp_id, exp_q[0].id);
                chk("rsp_q", rsp_q, exp_q[0].q);
                chk("rsp_flags", {rsp_dbz, rsp_ovf, rsp_tmo},
                    {exp_q[0].dbz, exp_q[0].ovf, exp_q[0].tmo});
                if (rsp_ready) begin
                    void'(exp_q.pop_front());
                    m_busy = 1'b0;
                end
            end

            if (exp_ready != '0) begin
                exp_t        e;
                logic [15:0] a, b;
                int          sa, sb, m;
                a = req_a[g];
                b = req_b[g];
                sa = int'($signed(a));
                sb = int'($signed(b));
                e.id = g;
                e.dbz = 1'b0;
                e.ovf = 1'b0;
                e.tmo = 1'b0;
                e.issue = -1;
                e.ma = 16'(mag(a));
                e.mb = 16'(mag(b));
                if (b == 16'h0000) begin
                    e.dbz = 1'b1;
                    e.q   = (sa > 0) ? 16'h7FFF : (sa < 0) ? 16'h8000 : 16'h0000;
                    e.due = cyc + 2;
                end else begin
                    e.issue = cyc + 1;
                    if (never_done) begin
                        e.q   = 16'h0000;
                        e.tmo = 1'b1;
                        e.due = cyc + 67;
                    end else begin
                        m = (mag(a) * 256) / mag(b);
                        if (m > 32767) begin
                            e.q   = 16'h8000;
                            e.ovf = 1'b1;
                        end else begin
                            e.q = ((sa < 0) != (sb < 0)) ? 16'(-m) : 16'(m);
                        end
                        e.due = cyc + 21;
                    end
                end
                exp_q.push_back(e);
                m_busy = 1'b1;
                m_ptr  = (g + 1) % N;
            end
        end
    end

    logic [15:0] r_q;
    int          r_id;
    logic        r_dbz, r_ovf, r_tmo;

    task automatic wait_grant(input int i);
        bit got = 1'b0;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            if (req_ready[i]) got = 1'b1;
        end
        if (!got) chk("grant_timeout", req_ready[i], 1);
    endtask

    task automatic issue(input int i, input logic [15:0] a, input logic [15:0] b);
        @(posedge clk);
        #1;
        req_a[i]     = a;
        req_b[i]     = b;
        req_valid[i] = 1'b1;
        wait_grant(i);
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp();
        bit got = 1'b0;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got   = 1'b1;
                r_q   = rsp_q;
                r_id  = int'(rsp_id);
                r_dbz = rsp_dbz;
                r_ovf = rsp_ovf;
                r_tmo = rsp_tmo;
            end
        end
        if (!got) chk("rsp_timeout", rsp_valid, 1);
    endtask

    initial begin
        int nr0, nv;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        nr0 = n_restart;
        issue(0, 16'h0300, 16'h0180);
        wait_rsp();
        chk("single_q", r_q, 16'h0200);
        chk("single_id", r_id, 0);
        chk("single_dbz", r_dbz, 0);
        chk("single_restarts", n_restart - nr0, 1);

        issue(0, 16'hFD00, 16'h0180);
        @(negedge clk);
        chk("neg_restart", div_restart, 1);
        chk("neg_div_a", div_a, 16'h0300);
        wait_rsp();
        chk("neg_q", r_q, 16'hFE00);

        issue(0, 16'hFD00, 16'hFE80);
        wait_rsp();
        chk("negneg_q", r_q, 16'h0200);

        nr0 = n_restart;
        issue(1, Q_ONE, 16'h0000);
        @(negedge clk);
        chk("zbyp_not_yet", rsp_valid, 0);
        @(negedge clk);
        chk("zbyp_valid", rsp_valid, 1);
        chk("zbyp_q", rsp_q, 16'h7FFF);
        chk("zbyp_dbz", rsp_dbz, 1);
        issue(1, 16'h0000, 16'h0000);
        wait_rsp();
        chk("zero_zero_q", r_q, 16'h0000);
        chk("zero_zero_dbz", r_dbz, 1);
        chk("zbyp_no_restart", n_restart - nr0, 0);

        issue(2, 16'h7F00, 16'h0001);
        wait_rsp();
        chk("ovf_q", r_q, 16'h8000);
        chk("ovf_flag", r_ovf, 1);

        // Reset while the divider is running.
        issue(1, 16'h0500, 16'h0200);
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_div_a", div_a, 16'h0000);
        nv = 0;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid) nv++;
        end
        chk("no_stale_rsp", nv, 0);
        issue(3, 16'h0300, 16'h0180);
        wait_rsp();
        chk("post_rst_q", r_q, 16'h0200);
        chk("post_rst_id", r_id, 3);

        // All requesters continuously active.
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            req_a[i] = 16'((i + 1) * 256);
            req_b[i] = Q_ONE;
        end
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            wait_rsp();
            chk("fair_id", r_id, k % N);
            chk("fair_q", r_q, 16'(((k % N) + 1) * 256));
        end
        @(posedge clk);
        #1 req_valid = '0;

        // Consumer stalls with another requester waiting.
        rsp_ready = 1'b0;
        issue(2, Q_ONE, 16'h0040);
        @(posedge clk);
        #1;
        req_a[0]     = 16'hFF00;
        req_b[0]     = 16'h0000;
        req_valid[0] = 1'b1;
        wait_rsp();
        chk("stall_q", r_q, 16'h0400);
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", rsp_valid, 1);
            chk("stall_q_hold", rsp_q, 16'h0400);
            chk("stall_id_hold", rsp_id, 2);
            chk("stall_no_accept", req_ready, 0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_grant(0);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        wait_rsp();
        chk("after_stall_q", r_q, 16'h8000);
        chk("after_stall_dbz", r_dbz, 1);

`ifdef FP_DIV_SCHED_WDOG_EN
        never_done = 1'b1;
        issue(1, Q_ONE, Q_ONE);
        wait_rsp();
        chk("wdog_tmo", r_tmo, 1);
        chk("wdog_q", r_q, 16'h0000);
        never_done = 1'b0;
`endif

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete, checks %0d", checks);
        $fatal(1);
    end

endmodule
